// File: rtl/q_8_34a_ctrl.sv
// Ones-counter controller: sequences load/incr/shift strobes for the R1/R2/E datapath.
// Optional shift watchdog enabled by defining Q_8_34A_CTRL_WATCHDOG_EN.
package q_8_34a_pkg;
    localparam int data_size = 8;
endpackage

module q_8_34a_ctrl
    import q_8_34a_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic zero,
    input  logic E,
    output logic load_regs,
    output logic incr_r2,
    output logic shift,
    output logic ready,
    output logic done,
    output logic err
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_1    = 2'd1,
        S_2    = 2'd2,
        S_3    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_done;
    logic   w_done_next;
    logic   w_busy_abort;
    logic   w_wd_trip;

    assign w_busy_abort = abort && (r_state != S_IDLE);

`ifdef Q_8_34A_CTRL_WATCHDOG_EN
    localparam int CNT_W = $clog2(data_size + 1);

    logic [CNT_W-1:0] r_shift_cnt;
    logic             r_err;

    // A full word of shifts without R1 reaching zero means the datapath is stuck.
    assign w_wd_trip = (r_state == S_2) && !abort && !zero
                       && (r_shift_cnt == CNT_W'(data_size));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (load_regs)
                r_shift_cnt <= '0;
            else if (shift)
                r_shift_cnt <= r_shift_cnt + 1'b1;

            if (load_regs)
                r_err <= 1'b0;
            else if (w_wd_trip)
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_wd_trip = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_next = S_1;
            end
            S_1: begin
                w_state_next = S_2;
            end
            S_2: begin
                if (zero) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end else if (w_wd_trip) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_3;
                end
            end
            S_3: begin
                w_state_next = E ? S_1 : S_2;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Abort wins over every busy-state transition and suppresses completion.
        if (w_busy_abort) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b0;
        end
    end

    always_comb begin
        load_regs = 1'b0;
        incr_r2   = 1'b0;
        shift     = 1'b0;
        ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready     = 1'b1;
                load_regs = start;
            end
            S_1: begin
                incr_r2 = !abort;
            end
            S_2: begin
                shift = !abort && !zero && !w_wd_trip;
            end
            default: begin
            end
        endcase
    end

    assign done = r_done;
endmodule

// File: tb/tb_q_8_34a_ctrl.sv
// Bench for q_8_34a_ctrl: behavioural R1/R2/E datapath plus a latency/popcount reference
// computed directly from the data word.
module tb_q_8_34a_ctrl;
    logic clk = 1'b0;
    logic rst, start, abort, zero, E;
    logic load_regs, incr_r2, shift, ready, done, err;

    logic [7:0] data_in = 8'h00;
    logic [7:0] r1      = 8'h00;
    logic [3:0] r2      = 4'h0;
    logic       e_q     = 1'b0;
    logic       force_z = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    q_8_34a_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .zero      (zero),
        .E         (E),
        .load_regs (load_regs),
        .incr_r2   (incr_r2),
        .shift     (shift),
        .ready     (ready),
        .done      (done),
        .err       (err)
    );

    // Datapath model driven by the controller's strobes.
    always @(posedge clk) begin
        if (load_regs) begin
            r1 <= data_in;
            r2 <= 4'hF;
        end else if (incr_r2) begin
            r2 <= r2 + 4'd1;
        end else if (shift) begin
            e_q <= r1[7];
            r1  <= {r1[6:0], 1'b0};
        end
    end

    assign zero = force_z ? 1'b0 : (r1 == 8'h00);
    assign E    = e_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int popcnt(input logic [7:0] d);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(d[i]);
        return n;
    endfunction

    // Shifts needed until R1 empties: position of lowest set bit counted from the MSB, plus 1.
    function automatic int nshifts(input logic [7:0] d);
        for (int i = 0; i < 8; i++)
            if (d[i]) return 8 - i;
        return 0;
    endfunction

    function automatic int exp_latency(input logic [7:0] d);
        return 3 + 2 * nshifts(d) + popcnt(d);
    endfunction

    // Caller is 1 time unit after a rising edge with the controller idle.
    task automatic run(input logic [7:0] d, input int abort_at, input int pulse_at);
        int exp_lat, ones, done_at, incrs;
        ones    = popcnt(d);
        exp_lat = exp_latency(d);
        done_at = -1;
        incrs   = 0;
        data_in = d;
        start   = 1'b1;
        #1;
        chk("c0_ready", ready, 1);
        chk("c0_load", load_regs, 1);
        @(posedge clk); #1;
        for (int c = 1; c <= 100; c++) begin
            start = (c == pulse_at);
            abort = (c == abort_at);
            #1;
            chk("strobe_onehot", (int'(load_regs) + int'(incr_r2) + int'(shift)) <= 1, 1);
            if (c == pulse_at) chk("start_ignored", load_regs, 0);
            if (c == abort_at) chk("abort_strobes", {load_regs, incr_r2, shift}, 0);
            incrs += int'(incr_r2);
            if (abort_at > 0 && c == abort_at + 1) begin
                chk("abort_ready", ready, 1);
                chk("abort_nodone", done, 0);
                done_at = -2;
                break;
            end
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        if (done_at == -2) begin
            @(posedge clk); #1;
            chk("abort_still_nodone", done, 0);
            $display("run d=%02h aborted at c%0d", d, abort_at);
        end else begin
            chk("latency", done_at, exp_lat);
            chk("popcount", r2, ones);
            chk("incr_pulses", incrs, ones + 1);
            chk("ready_with_done", ready, 1);
            @(posedge clk); #1;
            chk("done_one_cycle", done, 0);
            $display("run d=%02h done at c%0d (expect c%0d) r2=%0d", d, done_at, exp_lat, r2);
        end
    endtask

    initial begin
        int got, nsh, ab;
        logic [7:0] d;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_strobes", {load_regs, incr_r2, shift}, 0);
        start = 1'b1;
        #1;
        chk("rst_load_follows_start", load_regs, 1);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run(8'h00, -1, -1);
        run(8'hA0, -1, -1);
        run(8'hFF, -1, -1);
        run(8'h01, -1, -1);
        run(8'hA0, -1, 4);
        run(8'hA0, 5, -1);

        // Reset in the middle of a 0xFF run.
        data_in = 8'hFF;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        chk("midrst_strobes", {incr_r2, shift}, 0);
        $display("reset asserted at c5 of d=ff run");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_nodone", done, 0);
        run(8'hFF, -1, -1);

        for (int k = 0; k < 24; k++) begin
            d  = 8'($urandom_range(0, 255));
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, exp_latency(d) - 1) : -1;
            run(d, ab, -1);
        end

        // R1 never reads as zero: only the watchdog can end the run.
        force_z = 1'b1;
        data_in = 8'h00;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got   = -1;
        nsh   = 0;
`ifdef Q_8_34A_CTRL_WATCHDOG_EN
        for (int c = 1; c <= 60; c++) begin
            #1;
            nsh += int'(shift);
            chk("wd_nodone", done, 0);
            if (err === 1'b1) begin
                got = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("wd_err_cycle", got, 19);
        chk("wd_shift_count", nsh, 8);
        chk("wd_ready", ready, 1);
        $display("watchdog err at c%0d after %0d shifts", got, nsh);
        force_z = 1'b0;
        @(posedge clk); #1;
        chk("wd_err_sticky", err, 1);
        run(8'h03, -1, -1);
        chk("wd_err_cleared", err, 0);
`else
        for (int c = 1; c <= 40; c++) begin
            #1;
            nsh += int'(shift);
            chk("nowd_err_low", err, 0);
            chk("nowd_nodone", done, 0);
            @(posedge clk); #1;
        end
        chk("nowd_kept_shifting", nsh >= 15, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort   = 1'b0;
        force_z = 1'b0;
        chk("nowd_abort_ready", ready, 1);
        chk("nowd_err_final", err, 0);
        $display("no watchdog: %0d shifts with zero forced low, err=%0d", nsh, err);
        @(posedge clk); #1;
        run(8'h03, -1, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
